// File: rtl/lpc_mailbox_pkg.sv
// Shared constants for the LPC mailbox: register offsets, STATUS bit positions,
// handshake state encodings and the I/O window decode.
package lpc_mailbox_pkg;

    localparam logic [2:0] OFS_DATA    = 3'd0;
    localparam logic [2:0] OFS_STATUS  = 3'd1;
    localparam logic [2:0] OFS_INT_EN  = 3'd2;
    localparam logic [2:0] OFS_IRQ_VEC = 3'd3;
    localparam logic [2:0] OFS_SCRATCH = 3'd4;

    localparam int ST_TX_NE    = 0;
    localparam int ST_RX_FULL  = 1;
    localparam int ST_RX_EMPTY = 2;
    localparam int ST_RX_OVF   = 3;
    localparam int ST_IRQ      = 7;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_ACK  = 1'b1
    } wr_state_e;

    typedef enum logic {
        R_IDLE  = 1'b0,
        R_DRIVE = 1'b1
    } rd_state_e;

    // The window is 8 bytes, so only address bits [15:3] take part in the match.
    function automatic logic in_window(input logic [15:0] addr, input logic [15:0] base);
        return addr[15:3] == base[15:3];
    endfunction

endpackage

// File: rtl/lpc_mailbox_sync_fifo.sv
// Single-clock FIFO with a registered store; the head entry is read combinationally.
module lpc_sync_fifo
    import lpc_mailbox_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     nrst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/lpc_mailbox.sv
// LPC I/O mailbox: 8-byte register window with host<->device FIFOs and SERIRQ request.
//
// state   | meaning
// W_IDLE  | waiting for a host write; a request is performed and acked in one cycle
// W_ACK   | write acked, waiting for the peripheral to drop lpc_data_wr_i
// R_IDLE  | waiting for a host read; read value is latched in rd_reg when seen
// R_DRIVE | rd_reg on the bus; side effects applied when lpc_data_req_i drops
module lpc_mailbox
    import lpc_mailbox_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR  = 16'h0E00,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic        clk_i,
    input  logic        nrst_i,
    input  logic [15:0] lpc_addr_i,
    inout  wire  [7:0]  lpc_data_io,
    input  logic        lpc_data_wr_i,
    output logic        lpc_wr_done_o,
    input  logic        lpc_data_req_i,
    output logic        lpc_data_rd_o,
    output logic [3:0]  irq_num_o,
    output logic        interrupt_o,
    input  logic [7:0]  tx_data_i,
    input  logic        tx_valid_i,
    output logic        tx_ready_o,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    input  logic        rx_ready_i
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    wr_state_e   wr_state_q, wr_state_d;
    rd_state_e   rd_state_q, rd_state_d;
    logic        wr_done_q, wr_done_d;
    logic        data_rd_q, data_rd_d;
    logic [7:0]  rd_reg_q, rd_reg_d;
    logic        rd_pop_q, rd_pop_d;
    logic        rd_clr_q, rd_clr_d;
    logic        int_en_q, int_en_d;
    logic [3:0]  irq_vec_q, irq_vec_d;
    logic [7:0]  scratch_q, scratch_d;
    logic        ovf_q, ovf_d;
    logic        interrupt_q, interrupt_d;

    logic [2:0]    ofs;
    logic          hit;
    logic          wr_fire, rd_done;
    logic [7:0]    status, rd_val;
    logic          tx_pop, tx_full, tx_empty;
    logic [7:0]    tx_rdata;
    logic [CW-1:0] tx_count;
    logic          rx_push, rx_full, rx_empty;
    logic [7:0]    rx_rdata;
    logic [CW-1:0] rx_count;

    assign ofs     = lpc_addr_i[2:0];
    assign hit     = in_window(lpc_addr_i, BASE_ADDR);
    assign wr_fire = (wr_state_q == W_IDLE) & lpc_data_wr_i;
    assign rd_done = (rd_state_q == R_DRIVE) & ~lpc_data_req_i;
    assign rx_push = wr_fire & hit & (ofs == OFS_DATA);
    assign tx_pop  = rd_done & rd_pop_q;

    lpc_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_i   (clk_i),
        .nrst_i  (nrst_i),
        .push_i  (tx_valid_i),
        .wdata_i (tx_data_i),
        .pop_i   (tx_pop),
        .rdata_o (tx_rdata),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .count_o (tx_count)
    );

    lpc_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_i   (clk_i),
        .nrst_i  (nrst_i),
        .push_i  (rx_push),
        .wdata_i (lpc_data_io),
        .pop_i   (rx_ready_i),
        .rdata_o (rx_rdata),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .count_o (rx_count)
    );

    always_comb begin
        status              = '0;
        status[ST_TX_NE]    = ~tx_empty;
        status[ST_RX_FULL]  = rx_full;
        status[ST_RX_EMPTY] = rx_empty;
        status[ST_RX_OVF]   = ovf_q;
        status[ST_IRQ]      = interrupt_q;
    end

    always_comb begin
        rd_val = 8'hFF;
        if (hit) begin
            case (ofs)
                OFS_DATA:    rd_val = tx_empty ? 8'hFF : tx_rdata;
                OFS_STATUS:  rd_val = status;
                OFS_INT_EN:  rd_val = {7'b0, int_en_q};
                OFS_IRQ_VEC: rd_val = {4'b0, irq_vec_q};
                OFS_SCRATCH: rd_val = scratch_q;
                default:     rd_val = 8'hFF;
            endcase
        end
    end

    always_comb begin
        wr_state_d  = wr_state_q;
        wr_done_d   = wr_done_q;
        rd_state_d  = rd_state_q;
        data_rd_d   = data_rd_q;
        rd_reg_d    = rd_reg_q;
        rd_pop_d    = rd_pop_q;
        rd_clr_d    = rd_clr_q;
        int_en_d    = int_en_q;
        irq_vec_d   = irq_vec_q;
        scratch_d   = scratch_q;
        ovf_d       = ovf_q;
        interrupt_d = int_en_q & (tx_count != '0);

        case (wr_state_q)
            W_IDLE: begin
                if (lpc_data_wr_i) begin
                    wr_state_d = W_ACK;
                    wr_done_d  = 1'b1;
                    if (hit) begin
                        case (ofs)
                            OFS_INT_EN:  int_en_d  = lpc_data_io[0];
                            OFS_IRQ_VEC: irq_vec_d = lpc_data_io[3:0];
                            OFS_SCRATCH: scratch_d = lpc_data_io;
                            default:     ;
                        endcase
                    end
                end
            end
            W_ACK: begin
                if (!lpc_data_wr_i) begin
                    wr_state_d = W_IDLE;
                    wr_done_d  = 1'b0;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase

        // Side effects are decided at request time so the address may move before completion.
        case (rd_state_q)
            R_IDLE: begin
                if (lpc_data_req_i) begin
                    rd_state_d = R_DRIVE;
                    data_rd_d  = 1'b1;
                    rd_reg_d   = rd_val;
                    rd_pop_d   = hit & (ofs == OFS_DATA) & ~tx_empty;
                    rd_clr_d   = hit & (ofs == OFS_STATUS);
                end
            end
            R_DRIVE: begin
                if (!lpc_data_req_i) begin
                    rd_state_d = R_IDLE;
                    data_rd_d  = 1'b0;
                    rd_pop_d   = 1'b0;
                    rd_clr_d   = 1'b0;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase

        // A new overflow wins over a STATUS read completing in the same cycle.
        if (rd_done && rd_clr_q) begin
            ovf_d = 1'b0;
        end
        if (rx_push && rx_full && !rx_ready_i) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            wr_state_q  <= W_IDLE;
            wr_done_q   <= 1'b0;
            rd_state_q  <= R_IDLE;
            data_rd_q   <= 1'b0;
            rd_reg_q    <= '0;
            rd_pop_q    <= 1'b0;
            rd_clr_q    <= 1'b0;
            int_en_q    <= 1'b0;
            irq_vec_q   <= '0;
            scratch_q   <= '0;
            ovf_q       <= 1'b0;
            interrupt_q <= 1'b0;
        end else begin
            wr_state_q  <= wr_state_d;
            wr_done_q   <= wr_done_d;
            rd_state_q  <= rd_state_d;
            data_rd_q   <= data_rd_d;
            rd_reg_q    <= rd_reg_d;
            rd_pop_q    <= rd_pop_d;
            rd_clr_q    <= rd_clr_d;
            int_en_q    <= int_en_d;
            irq_vec_q   <= irq_vec_d;
            scratch_q   <= scratch_d;
            ovf_q       <= ovf_d;
            interrupt_q <= interrupt_d;
        end
    end

    assign lpc_data_io   = (rd_state_q == R_DRIVE) ? rd_reg_q : 8'hzz;
    assign lpc_wr_done_o = wr_done_q;
    assign lpc_data_rd_o = data_rd_q;
    assign irq_num_o     = irq_vec_q;
    assign interrupt_o   = interrupt_q;
    assign tx_ready_o    = ~tx_full;
    assign rx_valid_o    = (rx_count != '0);
    assign rx_data_o     = rx_rdata;

endmodule

// File: tb/tb_lpc_mailbox.sv
// Scoreboard bench for lpc_mailbox: host handshakes, device FIFO ports, window decode, reset.
module tb_lpc_mailbox;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [15:0] addr = '0;
    logic        wr = 1'b0;
    logic        req = 1'b0;
    logic [7:0]  drv = '0;
    logic        drv_en = 1'b0;
    logic [7:0]  tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        rx_ready = 1'b0;

    wire  [7:0]  lpc_data;
    logic        wr_done, data_rd, interrupt, tx_ready, rx_valid;
    logic [3:0]  irq_num;
    logic [7:0]  rx_data;

    assign lpc_data = drv_en ? drv : 8'hzz;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_exp[$];
    logic [7:0] tx_model[$];

    lpc_mailbox #(.BASE_ADDR(16'h0E00), .FIFO_DEPTH(16)) dut (
        .clk_i          (clk),
        .nrst_i         (nrst),
        .lpc_addr_i     (addr),
        .lpc_data_io    (lpc_data),
        .lpc_data_wr_i  (wr),
        .lpc_wr_done_o  (wr_done),
        .lpc_data_req_i (req),
        .lpc_data_rd_o  (data_rd),
        .irq_num_o      (irq_num),
        .interrupt_o    (interrupt),
        .tx_data_i      (tx_data),
        .tx_valid_i     (tx_valid),
        .tx_ready_o     (tx_ready),
        .rx_data_o      (rx_data),
        .rx_valid_o     (rx_valid),
        .rx_ready_i     (rx_ready)
    );

    always #5 clk = ~clk;

    task automatic host_write(input logic [15:0] a, input logic [7:0] d, output int lat);
        int n;
        @(posedge clk); #1;
        addr = a; drv = d; drv_en = 1'b1; wr = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!wr_done && n < 20);
        lat = wr_done ? n : 99;
        wr = 1'b0; drv_en = 1'b0;
        n = 0;
        while (wr_done && n < 20) begin @(posedge clk); #1; n++; end
        if (wr_done) lat = 99;
    endtask

    task automatic host_read(input logic [15:0] a, output logic [7:0] d, output int lat);
        int n;
        @(posedge clk); #1;
        addr = a; req = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!data_rd && n < 20);
        lat = data_rd ? n : 99;
        d = lpc_data;
        req = 1'b0;
        n = 0;
        while (data_rd && n < 20) begin @(posedge clk); #1; n++; end
        if (data_rd) lat = 99;
    endtask

    task automatic dev_push(input logic [7:0] d);
        @(posedge clk); #1;
        tx_data = d; tx_valid = 1'b1;
        if (tx_model.size() < 16) tx_model.push_back(d);
        @(posedge clk); #1;
        tx_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (wr_done !== 1'b0) begin bad++; $display("FAIL rst_wr_done got=%b exp=0", wr_done); end
        total++; if (data_rd !== 1'b0) begin bad++; $display("FAIL rst_data_rd got=%b exp=0", data_rd); end
        total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL rst_interrupt got=%b exp=0", interrupt); end
        total++; if (irq_num !== 4'h0) begin bad++; $display("FAIL rst_irq_num got=%h exp=0", irq_num); end
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL rst_tx_ready got=%b exp=1", tx_ready); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rst_rx_valid got=%b exp=0", rx_valid); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rst_rx_data got=%h exp=00", rx_data); end
        drv = 8'h00; drv_en = 1'b1; #1;
        total++; if (lpc_data !== 8'h00) begin bad++; $display("FAIL rst_bus_released got=%h exp=00", lpc_data); end
        drv_en = 1'b0;
        @(posedge clk); #1;
        nrst = 1'b1;
    endtask

    task automatic test_scratch();
        logic [7:0] d, e;
        int lat;
        host_write(16'h0E04, 8'hA5, lat);
        total++; if (lat !== 1) begin bad++; $display("FAIL scratch_wr_latency got=%0d exp=1", lat); end
        exp_q.push_back(8'hA5);
        host_read(16'h0E04, d, lat);
        e = exp_q.pop_front();
        total++; if (d !== e) begin bad++; $display("FAIL scratch_rd got=%h exp=%h", d, e); end
        total++; if (lat !== 1) begin bad++; $display("FAIL scratch_rd_latency got=%0d exp=1", lat); end
    endtask

    task automatic test_irq();
        logic [7:0] d, e;
        int lat;
        host_write(16'h0E02, 8'hFF, lat);
        host_write(16'h0E03, 8'hF3, lat);
        exp_q.push_back(8'h01);
        host_read(16'h0E02, d, lat);
        e = exp_q.pop_front();
        total++; if (d !== e) begin bad++; $display("FAIL int_en_rd got=%h exp=%h", d, e); end
        exp_q.push_back(8'h03);
        host_read(16'h0E03, d, lat);
        e = exp_q.pop_front();
        total++; if (d !== e) begin bad++; $display("FAIL irq_vec_rd got=%h exp=%h", d, e); end
        total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL irq_idle got=%b exp=0", interrupt); end
        dev_push(8'h11);
        dev_push(8'h22);
        total++; if (interrupt !== 1'b1) begin bad++; $display("FAIL irq_raised got=%b exp=1", interrupt); end
        total++; if (irq_num !== 4'h3) begin bad++; $display("FAIL irq_num got=%h exp=3", irq_num); end
        exp_q.push_back(8'h85);
        host_read(16'h0E01, d, lat);
        e = exp_q.pop_front();
        total++; if (d !== e) begin bad++; $display("FAIL irq_status got=%h exp=%h", d, e); end
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(tx_model.pop_front());
            host_read(16'h0E00, d, lat);
            e = exp_q.pop_front();
            total++; if (d !== e) begin bad++; $display("FAIL irq_data_rd%0d got=%h exp=%h", i, d, e); end
        end
        @(posedge clk); #1;
        total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL irq_fall got=%b exp=0", interrupt); end
    endtask

    task automatic test_rx_overflow();
        logic [7:0] d, e;
        int lat;
        for (int i = 0; i < 16; i++) begin
            host_write(16'h0E00, 8'h40 + 8'(i), lat);
            rx_exp.push_back(8'h40 + 8'(i));
        end
        total++; if (rx_valid !== 1'b1 || rx_data !== 8'h40) begin bad++; $display("FAIL rx_head got=%b/%h exp=1/40", rx_valid, rx_data); end
        host_write(16'h0E00, 8'hEE, lat);
        total++; if (lat !== 1) begin bad++; $display("FAIL rx_ovf_ack got=%0d exp=1", lat); end
        exp_q.push_back(8'h0A);
        host_read(16'h0E01, d, lat);
        e = exp_q.pop_front();
        total++; if (d !== e) begin bad++; $display("FAIL rx_ovf_status got=%h exp=%h", d, e); end
        exp_q.push_back(8'h02);
        host_read(16'h0E01, d, lat);
        e = exp_q.pop_front();
        total++; if (d !== e) begin bad++; $display("FAIL rx_ovf_cleared got=%h exp=%h", d, e); end
        // full RX: host push and device pop on the same edge both take effect
        @(posedge clk); #1;
        e = rx_exp.pop_front();
        total++; if (rx_data !== e) begin bad++; $display("FAIL rx_simul_head got=%h exp=%h", rx_data, e); end
        addr = 16'h0E00; drv = 8'h77; drv_en = 1'b1; wr = 1'b1; rx_ready = 1'b1;
        rx_exp.push_back(8'h77);
        @(posedge clk); #1;
        rx_ready = 1'b0; wr = 1'b0; drv_en = 1'b0;
        total++; if (wr_done !== 1'b1) begin bad++; $display("FAIL rx_simul_ack got=%b exp=1", wr_done); end
        @(posedge clk); #1;
        exp_q.push_back(8'h02);
        host_read(16'h0E01, d, lat);
        e = exp_q.pop_front();
        total++; if (d !== e) begin bad++; $display("FAIL rx_simul_status got=%h exp=%h", d, e); end
        for (int i = 0; i < 16; i++) begin
            e = rx_exp.pop_front();
            total++; if (rx_valid !== 1'b1 || rx_data !== e) begin bad++; $display("FAIL rx_drain%0d got=%b/%h exp=1/%h", i, rx_valid, rx_data, e); end
            rx_ready = 1'b1;
            @(posedge clk); #1;
            rx_ready = 1'b0;
        end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rx_drained got=%b exp=0", rx_valid); end
    endtask

    task automatic test_window();
        logic [15:0] rd_addr [7] = '{16'h0E00, 16'h0E01, 16'h0080, 16'h0E05, 16'h0E07, 16'h0E0C, 16'h0E04};
        logic [7:0]  rd_exp  [7] = '{8'hFF,    8'h04,    8'hFF,    8'hFF,    8'hFF,    8'hFF,    8'hA5};
        logic [7:0] d, e;
        int lat;
        host_write(16'h0084, 8'h77, lat);
        total++; if (lat !== 1) begin bad++; $display("FAIL outside_wr_ack got=%0d exp=1", lat); end
        host_write(16'h0E06, 8'h55, lat);
        total++; if (lat !== 1) begin bad++; $display("FAIL unmapped_wr_ack got=%0d exp=1", lat); end
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(rd_exp[i]);
            host_read(rd_addr[i], d, lat);
            e = exp_q.pop_front();
            total++; if (d !== e || lat !== 1) begin bad++; $display("FAIL window_rd_%h got=%h lat=%0d exp=%h lat=1", rd_addr[i], d, lat, e); end
        end
        total++; if (tx_ready !== 1'b1 || rx_valid !== 1'b0) begin bad++; $display("FAIL window_fifo_state got=%b/%b exp=1/0", tx_ready, rx_valid); end
    endtask

    task automatic test_abort();
        logic [7:0] d, e;
        int lat;
        dev_push(8'h5B);
        @(posedge clk); #1;
        addr = 16'h0E00; req = 1'b1;
        #3 req = 1'b0;
        @(posedge clk); #1;
        total++; if (data_rd !== 1'b0) begin bad++; $display("FAIL abort_no_ack got=%b exp=0", data_rd); end
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(tx_model.size() != 0 ? tx_model.pop_front() : 8'hFF);
            host_read(16'h0E00, d, lat);
            e = exp_q.pop_front();
            total++; if (d !== e) begin bad++; $display("FAIL abort_data_rd%0d got=%h exp=%h", i, d, e); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d, e;
        int lat, n;
        for (int i = 0; i < 16; i++) dev_push(8'h80 + 8'(i));
        total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL tx_full_ready got=%b exp=0", tx_ready); end
        dev_push(8'hDD);
        @(posedge clk); #1;
        addr = 16'h0E00; req = 1'b1;
        @(posedge clk); #1;
        e = tx_model.pop_front();
        total++; if (data_rd !== 1'b1 || lpc_data !== e) begin bad++; $display("FAIL tx_simul_rd got=%b/%h exp=1/%h", data_rd, lpc_data, e); end
        req = 1'b0; tx_data = 8'hC0; tx_valid = 1'b1;
        tx_model.push_back(8'hC0);
        @(posedge clk); #1;
        tx_valid = 1'b0;
        total++; if (data_rd !== 1'b0 || tx_ready !== 1'b0) begin bad++; $display("FAIL tx_simul_count got=%b/%b exp=0/0", data_rd, tx_ready); end
        n = 0;
        for (int i = 0; i < 17; i++) begin
            exp_q.push_back(tx_model.size() != 0 ? tx_model.pop_front() : 8'hFF);
            host_read(16'h0E00, d, lat);
            e = exp_q.pop_front();
            if (d !== e) n++;
            total++; if (d !== e) begin bad++; $display("FAIL tx_drain%0d got=%h exp=%h", i, d, e); end
        end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] d, e;
        int lat;
        dev_push(8'h99);
        @(posedge clk); #1;
        addr = 16'h0E00; req = 1'b1;
        @(posedge clk); #1;
        total++; if (data_rd !== 1'b1 || lpc_data !== 8'h99) begin bad++; $display("FAIL mid_rd_drive got=%b/%h exp=1/99", data_rd, lpc_data); end
        drv = 8'h00; drv_en = 1'b1; nrst = 1'b0;
        #1;
        total++; if (lpc_data !== 8'h00 || data_rd !== 1'b0) begin bad++; $display("FAIL mid_rd_release got=%h/%b exp=00/0", lpc_data, data_rd); end
        req = 1'b0; drv_en = 1'b0;
        tx_model.delete();
        @(posedge clk); @(posedge clk); #1;
        nrst = 1'b1;
        total++; if (tx_ready !== 1'b1 || rx_valid !== 1'b0 || interrupt !== 1'b0) begin bad++; $display("FAIL mid_rd_flush got=%b/%b/%b exp=1/0/0", tx_ready, rx_valid, interrupt); end
        exp_q.push_back(8'h04);
        host_read(16'h0E01, d, lat);
        e = exp_q.pop_front();
        total++; if (d !== e) begin bad++; $display("FAIL mid_rd_status got=%h exp=%h", d, e); end
        exp_q.push_back(8'hFF);
        host_read(16'h0E00, d, lat);
        e = exp_q.pop_front();
        total++; if (d !== e) begin bad++; $display("FAIL mid_rd_data got=%h exp=%h", d, e); end
        exp_q.push_back(8'h00);
        host_read(16'h0E04, d, lat);
        e = exp_q.pop_front();
        total++; if (d !== e) begin bad++; $display("FAIL mid_rd_scratch got=%h exp=%h", d, e); end
    endtask

    initial begin
        test_reset();
        test_scratch();
        test_irq();
        test_rx_overflow();
        test_window();
        test_abort();
        test_back_to_back();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
